// File: rtl/qpsk_demod.sv
// qpsk_demod: correlating QPSK demodulator that makes a hard I/Q decision for
// each 16-sample symbol of offset-binary input. Decided symbols leave through a
// 1-entry valid/ready register, and a sticky overrun flag is set when a decision
// has to be dropped.
// Optional feature macro: QPSK_DEMOD_SOFT_EN adds the soft_i/soft_q outputs.
module qpsk_demod #(
   parameter int SAMPLE_W = 9,
   parameter int MIDSCALE = 256
`ifdef QPSK_DEMOD_SOFT_EN
   ,parameter int SOFT_SHIFT = 12
`endif
) (
   input  logic                clk,
   input  logic                rst_n,
   input  logic [SAMPLE_W-1:0] sample_in,
   input  logic                sample_valid,
   input  logic                sym_start,
   output logic                sym_valid,
   input  logic                sym_ready,
   output logic                i_bit,
   output logic                q_bit,
   output logic                overrun
`ifdef QPSK_DEMOD_SOFT_EN
   ,output logic signed [7:0]  soft_i,
   output logic signed [7:0]   soft_q
`endif
);

   localparam int SPS    = 16;
   localparam int X_W    = SAMPLE_W + 1;
   localparam int PROD_W = X_W + 8;
   localparam int ACC_W  = PROD_W + $clog2(SPS);
   localparam logic signed [X_W-1:0] MID_S = X_W'(MIDSCALE);

   typedef enum logic {IDLE, ACQ} state_t;

   state_t                    state_q, state_d;
   logic [3:0]                k_p0;
   logic signed [ACC_W-1:0]   acc_i_p0, acc_q_p0;
   logic signed [X_W-1:0]     x;
   logic [3:0]                ph;
   logic                      active, last;
   logic signed [PROD_W-1:0]  prod_i, prod_q;
   logic signed [ACC_W-1:0]   acc_nxt_i, acc_nxt_q;
   logic                      vld_p1, i_bit_p1, q_bit_p1, overrun_p1;

   // round(127*cos(2*pi*k/16))
   function automatic logic signed [7:0] cos_lut(input logic [3:0] k);
      case (k)
         4'd0:  return 8'sd127;
         4'd1:  return 8'sd117;
         4'd2:  return 8'sd90;
         4'd3:  return 8'sd49;
         4'd4:  return 8'sd0;
         4'd5:  return -8'sd49;
         4'd6:  return -8'sd90;
         4'd7:  return -8'sd117;
         4'd8:  return -8'sd127;
         4'd9:  return -8'sd117;
         4'd10: return -8'sd90;
         4'd11: return -8'sd49;
         4'd12: return 8'sd0;
         4'd13: return 8'sd49;
         4'd14: return 8'sd90;
         default: return 8'sd117;
      endcase
   endfunction

   // sin is cos delayed by four phases
   function automatic logic signed [7:0] sin_lut(input logic [3:0] k);
      return cos_lut(k - 4'd4);
   endfunction

   // strictly positive; an exact zero sum decides 0
   function automatic logic is_pos(input logic signed [ACC_W-1:0] a);
      return !a[ACC_W-1] && (a != '0);
   endfunction

`ifdef QPSK_DEMOD_SOFT_EN
   localparam logic signed [ACC_W-1:0] SAT_HI = ACC_W'(127);
   localparam logic signed [ACC_W-1:0] SAT_LO = ACC_W'(-128);

   function automatic logic signed [7:0] sat8(input logic signed [ACC_W-1:0] a);
      logic signed [ACC_W-1:0] sh;
      sh = a >>> SOFT_SHIFT;
      if (sh > SAT_HI)      return 8'sh7f;
      else if (sh < SAT_LO) return 8'sh80;
      else                  return sh[7:0];
   endfunction

   logic signed [7:0] soft_i_p1, soft_q_p1;
`endif

   // p0: centre the sample, pick the phase, and form the products and next sums
   always_comb begin
      x         = $signed({1'b0, sample_in}) - MID_S;
      ph        = sym_start ? 4'd0 : k_p0;
      active    = sample_valid && (state_q == ACQ || sym_start);
      last      = active && (ph == 4'd15);
      prod_i    = PROD_W'(x) * PROD_W'(cos_lut(ph));
      prod_q    = PROD_W'(x) * PROD_W'(sin_lut(ph));
      acc_nxt_i = (sym_start ? '0 : acc_i_p0) + ACC_W'(prod_i);
      acc_nxt_q = (sym_start ? '0 : acc_q_p0) + ACC_W'(prod_q);
   end

   // FSM state register
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state_q <= IDLE;
      else        state_q <= state_d;
   end

   // FSM next state: the first qualified sym_start leaves IDLE; ACQ is held thereafter
   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE:    if (sample_valid && sym_start) state_d = ACQ;
         default: state_d = ACQ;
      endcase
   end

   // phase counter and accumulators; cleared after phase 15 so the next symbol starts clean
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         k_p0     <= '0;
         acc_i_p0 <= '0;
         acc_q_p0 <= '0;
      end else if (active) begin
         if (last) begin
            k_p0     <= '0;
            acc_i_p0 <= '0;
            acc_q_p0 <= '0;
         end else begin
            k_p0     <= ph + 4'd1;
            acc_i_p0 <= acc_nxt_i;
            acc_q_p0 <= acc_nxt_q;
         end
      end
   end

   // p1: 1-entry output register; a decision that arrives while the register is full and stalled is dropped
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         vld_p1     <= 1'b0;
         i_bit_p1   <= 1'b0;
         q_bit_p1   <= 1'b0;
         overrun_p1 <= 1'b0;
`ifdef QPSK_DEMOD_SOFT_EN
         soft_i_p1  <= '0;
         soft_q_p1  <= '0;
`endif
      end else if (last) begin
         if (!vld_p1 || sym_ready) begin
            vld_p1   <= 1'b1;
            i_bit_p1 <= is_pos(acc_nxt_i);
            q_bit_p1 <= is_pos(acc_nxt_q);
`ifdef QPSK_DEMOD_SOFT_EN
            soft_i_p1 <= sat8(acc_nxt_i);
            soft_q_p1 <= sat8(acc_nxt_q);
`endif
         end else begin
            overrun_p1 <= 1'b1;
         end
      end else if (vld_p1 && sym_ready) begin
         vld_p1 <= 1'b0;
      end
   end

   assign sym_valid = vld_p1;
   assign i_bit     = i_bit_p1;
   assign q_bit     = q_bit_p1;
   assign overrun   = overrun_p1;
`ifdef QPSK_DEMOD_SOFT_EN
   assign soft_i    = soft_i_p1;
   assign soft_q    = soft_q_p1;
`endif

endmodule
